rr_bus_fabric: RTL and testbench

Parametrised multi-master shared-bus block: N request channels, each with a one-entry request buffer, a round-robin arbiter and a registered shared data bus. It generalises the fixed three-master, fixed-priority, 2-bit bus to configurable channel count, data width and grant hold time. It adds fairness, back-to-back grants and a transfer counter. The bus output feeds the display or downstream logic directly.

---
 rtl/rr_bus_fabric.sv | 87 ++++++++
 tb/tb_rr_bus_fabric.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rr_bus_fabric.sv
// rr_bus_fabric: N-channel buffered shared bus with round-robin grant, fixed hold time and transfer counter
module rr_bus_fabric #(
  parameter int N_CH        = 3,
  parameter int DATA_W      = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  output logic [N_CH-1:0]          grant,
  output logic [N_CH-1:0]          ack,
  output logic [N_CH-1:0]          pending,
  output logic [DATA_W-1:0]        bus_data,
  output logic                     bus_valid,
  output logic [CNT_W-1:0]         xfer_count
);
  localparam int LW = $clog2(N_CH);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            r_state, w_next;
  logic [HW-1:0]     r_hold;
  logic [LW-1:0]     r_last, w_sel, w_j;
  logic [N_CH-1:0]   r_pending, r_grant, r_ack, w_cand, w_owner;
  logic [DATA_W-1:0] r_buf [N_CH];
  logic [DATA_W-1:0] r_bus;
  logic              r_valid, w_final, w_found, w_arb;
  logic [CNT_W-1:0]  r_cnt;
  assign w_owner = N_CH'(1) << r_last;
  assign w_final = r_state == GRANT && r_hold == HW'(HOLD_CYCLES - 1);
  // the releasing owner is excluded so others get the bus first
  assign w_cand  = r_pending & ~(w_final ? w_owner : '0);
  assign w_found = |w_cand;
  assign w_arb   = (r_state == IDLE || w_final) && w_found;
  // scan from farthest to nearest so the nearest candidate after r_last wins
  always_comb begin
    w_sel = r_last;
    w_j   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      w_j = LW'((int'(r_last) + k) % N_CH);
      if (w_cand[w_j]) w_sel = w_j;
    end
  end
  always_comb w_next = (r_state == IDLE || w_final) ? (w_found ? GRANT : IDLE) : GRANT;
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold    <= '0;
      r_last    <= LW'(N_CH - 1);
      r_pending <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_bus     <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      for (int i = 0; i < N_CH; i++) r_buf[i] <= '0;
    end else begin
      r_ack  <= w_final ? w_owner : '0;
      r_cnt  <= r_cnt + CNT_W'(w_final);
      r_hold <= (r_state == GRANT && !w_final) ? r_hold + 1'b1 : '0;
      if (w_arb) begin
        r_last  <= w_sel;
        r_grant <= N_CH'(1) << w_sel;
        r_bus   <= r_buf[w_sel];
        r_valid <= 1'b1;
      end else if (w_final) begin
        r_grant <= '0;
        r_valid <= 1'b0;
      end
      for (int i = 0; i < N_CH; i++)
        if (w_final && w_owner[i]) r_pending[i] <= 1'b0;
        else if (!r_pending[i] && req_in[i]) begin
          r_pending[i] <= 1'b1;
          r_buf[i]     <= data_in[i*DATA_W +: DATA_W];
        end
    end
  end
  always_comb begin
    grant      = r_grant;
    ack        = r_ack;
    pending    = r_pending;
    bus_data   = r_bus;
    bus_valid  = r_valid;
    xfer_count = r_cnt;
  end
endmodule

// File: tb/tb_rr_bus_fabric.sv
// tb_rr_bus_fabric: vector table, hand sequences and a randomized reference-model run
module tb_rr_bus_fabric;
  localparam int N = 3, DW = 2, H = 4, CW = 8;
  localparam int N1 = 4, DW1 = 4, H1 = 1, CW1 = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, bv0;
  logic [N-1:0] req0, g0, a0, p0;
  logic [N*DW-1:0] din0;
  logic [DW-1:0] bd0;
  logic [CW-1:0] xc0;
  logic rst1, bv1;
  logic [N1-1:0] req1, g1, a1, p1;
  logic [N1*DW1-1:0] din1;
  logic [DW1-1:0] bd1;
  logic [CW1-1:0] xc1;
  rr_bus_fabric #(.N_CH(N), .DATA_W(DW), .HOLD_CYCLES(H), .CNT_W(CW)) u0 (
    .clk(clk), .reset(rst0), .req_in(req0), .data_in(din0), .grant(g0), .ack(a0),
    .pending(p0), .bus_data(bd0), .bus_valid(bv0), .xfer_count(xc0));
  rr_bus_fabric #(.N_CH(N1), .DATA_W(DW1), .HOLD_CYCLES(H1), .CNT_W(CW1)) u1 (
    .clk(clk), .reset(rst1), .req_in(req1), .data_in(din1), .grant(g1), .ack(a1),
    .pending(p1), .bus_data(bd1), .bus_valid(bv1), .xfer_count(xc1));
  int pass_cnt = 0, tot = 0;
  bit mdl_on = 1'b0;
  task automatic chk(string name, int act, int exp);
    tot++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  typedef struct {
    logic rst; logic [2:0] req; logic [5:0] din;
    logic [2:0] g, a, p; logic [1:0] bd; logic bv; logic [7:0] xc;
  } vec_t;
  vec_t tbl[$];
  task automatic add(bit r, int rq, int d, int g, int a, int p, int b, int v, int c);
    vec_t x;
    x.rst = r; x.req = 3'(rq); x.din = 6'(d); x.g = 3'(g); x.a = 3'(a);
    x.p = 3'(p); x.bd = 2'(b); x.bv = v[0]; x.xc = 8'(c);
    tbl.push_back(x);
  endtask
  // reference model: owner index with a countdown of remaining bus cycles
  logic [N-1:0] m_pend, m_ack;
  logic [DW-1:0] m_buf [N];
  logic [DW-1:0] m_bus;
  logic m_valid;
  int m_own, m_left, m_last, m_cnt;
  function automatic int pick(logic [N-1:0] mask, int last);
    for (int k = 1; k <= N; k++) if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic model_step();
    logic [N-1:0] old;
    int s;
    if (rst0) begin
      m_pend = '0; m_ack = '0; m_bus = '0; m_valid = 1'b0;
      m_own = -1; m_left = 0; m_last = N - 1; m_cnt = 0;
      for (int i = 0; i < N; i++) m_buf[i] = '0;
    end else begin
      old = m_pend; m_ack = '0; s = -1;
      for (int i = 0; i < N; i++)
        if (!old[i] && req0[i]) begin m_pend[i] = 1'b1; m_buf[i] = din0[i*DW +: DW]; end
      if (m_own < 0) s = pick(old, m_last);
      else if (m_left > 1) m_left--;
      else begin
        m_ack[m_own] = 1'b1; m_pend[m_own] = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CW);
        s = pick(old & ~(N'(1) << m_own), m_last);
        m_own = -1; m_valid = 1'b0;
      end
      if (s >= 0) begin m_own = s; m_left = H; m_last = s; m_bus = m_buf[s]; m_valid = 1'b1; end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (mdl_on) model_step();
    #1;
  endtask
  int order[$];
  int fexp[4] = '{0, 2, 0, 0};
  logic [N-1:0] prev;
  int eg[5] = '{1, 2, 4, 8, 0};
  int ea[5] = '{0, 1, 2, 4, 8};
  int ec[5] = '{0, 1, 2, 3, 0};
  int eb[5] = '{5, 6, 7, 8, 8};
  int ev[5] = '{1, 1, 1, 1, 0};
  initial begin
    rst0 = 1'b1; req0 = '0; din0 = '0;
    rst1 = 1'b1; req1 = '0; din1 = '0;
    #2;
    for (int k = 0; k < 3; k++) add(1, 7, 63, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2, 8, 0, 0, 2, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 2, 0, 2, 2, 1, 0);
    add(0, 0, 0, 0, 2, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 7, 57, 0, 0, 7, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 0, 7, 1, 1, 0);
    add(0, 0, 0, 2, 1, 6, 2, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 2, 0, 6, 2, 1, 1);
    add(0, 0, 0, 4, 2, 4, 3, 1, 2);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 4, 0, 4, 3, 1, 2);
    add(0, 0, 0, 0, 4, 0, 3, 0, 3);
    add(0, 0, 0, 0, 0, 0, 3, 0, 3);
    add(0, 1, 1, 0, 0, 1, 3, 0, 3);
    add(0, 0, 0, 1, 0, 1, 1, 1, 3);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      rst0 = tbl[i].rst; req0 = tbl[i].req; din0 = tbl[i].din;
      tick();
      chk($sformatf("vec%0d grant", i), int'(g0), int'(tbl[i].g));
      chk($sformatf("vec%0d ack", i), int'(a0), int'(tbl[i].a));
      chk($sformatf("vec%0d pending", i), int'(p0), int'(tbl[i].p));
      chk($sformatf("vec%0d bus_data", i), int'(bd0), int'(tbl[i].bd));
      chk($sformatf("vec%0d bus_valid", i), int'(bv0), int'(tbl[i].bv));
      chk($sformatf("vec%0d xfer_count", i), int'(xc0), int'(tbl[i].xc));
    end
    rst0 = 1'b1; req0 = '0; tick();
    rst0 = 1'b0; req0 = 3'b101; din0 = '0; tick();
    req0 = 3'b001; prev = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (g0 != '0 && g0 != prev) order.push_back($clog2(g0));
      prev = g0;
    end
    chk("fair grant count", int'(order.size() >= 4), 1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("fair order%0d", k), k < order.size() ? order[k] : -1, fexp[k]);
    req0 = '0; rst0 = 1'b1;
    rst1 = 1'b1; tick();
    rst1 = 1'b0; req1 = 4'hF; din1 = {4'd8, 4'd7, 4'd6, 4'd5}; tick();
    chk("hold1 pending", int'(p1), 15);
    chk("hold1 idle grant", int'(g1), 0);
    req1 = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold1 c%0d grant", k), int'(g1), eg[k]);
      chk($sformatf("hold1 c%0d ack", k), int'(a1), ea[k]);
      chk($sformatf("hold1 c%0d count", k), int'(xc1), ec[k]);
      chk($sformatf("hold1 c%0d bus", k), int'(bd1), eb[k]);
      chk($sformatf("hold1 c%0d valid", k), int'(bv1), ev[k]);
    end
    chk("hold1 pending done", int'(p1), 0);
    mdl_on = 1'b1; rst0 = 1'b1; tick();
    for (int c = 0; c < 1500; c++) begin
      rst0 = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++) req0[i] = ($urandom_range(0, 9) < 3);
      din0 = N*DW'($urandom);
      tick();
      chk("rnd grant", int'(g0), m_own < 0 ? 0 : int'(N'(1) << m_own));
      chk("rnd ack", int'(a0), int'(m_ack));
      chk("rnd pending", int'(p0), int'(m_pend));
      chk("rnd bus_data", int'(bd0), int'(m_bus));
      chk("rnd bus_valid", int'(bv0), int'(m_valid));
      chk("rnd xfer_count", int'(xc0), m_cnt);
    end
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
